instr_encoder: RTL and testbench
================================

# instr_encoder

Packs decoded instruction fields plus a 32-bit immediate into RV32 instruction words, the inverse of the ID-stage immediate generator. It sits in front of the boot/test instruction ROM loader and the self-check harness. Requests arrive over a valid/ready handshake and leave as registered instruction words over a second valid/ready handshake. A built-in LI pseudo-op expands a 32-bit constant into LUI/ADDI as one or two words.

## Interface
- CHECK_RANGE, 1, when 1 immediate range/alignment errors raise out_err; when 0 out_err is tied 0
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=LI, 7=reserved
- in_opcode  in  7  opcode bits [6:0]; ignored for LI
- in_funct3  in  3  funct3; ignored for U, J, LI
- in_funct7  in  7  funct7; R only
- in_rd, in_rs1, in_rs2  in  5 each  register indices; used per format
- in_imm  in  32  immediate as a signed byte offset or value; U takes the full value, so imm[11:0] must be 0
- out_valid  out  1  word valid
- out_ready  in  1  word consumed when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_err  out  1  range/alignment/format error for this word
- out_last  out  1  final word of the request; always 1 except the LUI half of a two-word LI

## Operation
- Field packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Errors (CHECK_RANGE=1):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0] set.
  - J: imm[31:20] not all equal, or imm[0] set.
  - U: imm[11:0] nonzero.
  - fmt=7: out_instr=0 with out_err=1.
  - On any error the word is still emitted with truncated fields; R never errors.
- LI, with lo = sign-extended imm[11:0] and hi = (imm + 0x800) >> 12, truncated to 20 bits:
  - imm[31:11] all equal: one word, ADDI rd, x0, lo (opcode 0010011, funct3 000).
  - else if imm[11:0]==0: one word, LUI rd, hi (opcode 0110111).
  - else: two words, LUI rd, hi (out_last=0) then ADDI rd, rd, lo (out_last=1).
  - LI never errors.
- FSM states:
  - IDLE: accepts requests.
  - SECOND: the ADDI word sits in a hold register; in_ready=0.
  - IDLE→SECOND on accepting a two-word LI.
  - SECOND→IDLE when the LUI word handshakes; the ADDI word loads into the output register on that same edge.

## Timing
- Reset values: out_valid=0, out_instr=0, out_err=0, out_last=0, state IDLE, hold register cleared.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational, so full throughput is 1 word/cycle.
- Latency: a request accepted at edge N produces out_valid at N+1.
- Second LI word appears the cycle after the first word handshakes, so there are no bubbles under constant out_ready.
- While out_valid && !out_ready, out_instr, out_err and out_last hold stable.
- Output register is single-entry. Same-cycle output handshake plus new input acceptance replaces the word without a bubble.
- Reset asserted mid-LI (in SECOND): both words are dropped, out_valid=0, and the block returns to IDLE immediately, since reset is asynchronous.
- Inputs are sampled only on the accepting edge and may change freely otherwise.

## Structure
- Shared package holds:
  - fmt codes FMT_R..FMT_LI and FMT_RSVD;
  - opcode constants OP_LUI=0110111 and OP_OPIMM=0010011;
  - funct3 constant F3_ADDI=000.
- One sub-module is natural: instr_pack, which is purely combinational. It takes fields, fmt and imm and returns instr plus err, and is instantiated twice (request word and LI second word).
- The FSM, hold register and output register live in the top.

## Test plan
- I: ADDI x1, x2, -1 (fmt=1, opcode 0x13, funct3 0, rd 1, rs1 2, imm 0xFFFFFFFF) -> out_instr 0xFFF10093, err 0, last 1, one cycle after accept.
- B and J:
  - beq x1, x2, +8 -> 0x00208463.
  - jal x0, -4 -> 0xFFDFF06F.
  - B with imm=3 -> out_err=1.
  - I with imm=0x800 -> out_err=1.
- LI x5, 0x12345678 -> 0x123452B7 (last 0), then 0x67828293 (last 1). LI x1, 0x800 -> 0x000010B7, then 0x80008093. LI x3, 5 -> single word 0x00500193.
- Backpressure: hold out_ready=0 for 3 cycles during the LI LUI word.
  - Word stable and in_ready=0 throughout.
  - Release: ADDI follows next cycle, and a new request is accepted only after that.
- Reset mid-op: drop rst_n in SECOND -> out_valid=0 asynchronously. After release, an R request (add x3, x1, x2) -> 0x002081B3.
- Throughput: 8 back-to-back I requests with out_ready=1 -> 8 words on 8 consecutive cycles, in order.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32 instruction encoder: format codes, opcodes
// and the FSM state type.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_LI   = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [2:0] F3_ADDI  = 3'b000;

    typedef enum logic {StIdle, StSecond} state_e;

    // True when v[31:lsb] are all ones or all zeros, i.e. v fits as a signed
    // value of lsb+1 bits.
    function automatic logic all_eq(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << lsb;
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32 field packer: places fields and immediate per format and
// flags immediates that do not fit or are misaligned.
module instr_pack
    import instr_encoder_pkg::*;
#(
    parameter bit CHECK_RANGE = 1'b1
) (
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic err_raw;

    always_comb begin
        instr_o = 32'h0;
        err_raw = 1'b0;
        unique case (fmt_i)
            FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                err_raw = !all_eq(imm_i, 11);
            end
            FMT_S: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                err_raw = !all_eq(imm_i, 11);
            end
            FMT_B: begin
                instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
                err_raw = !all_eq(imm_i, 12) || imm_i[0];
            end
            FMT_U: begin
                instr_o = {imm_i[31:12], rd_i, opcode_i};
                err_raw = (imm_i[11:0] != 12'h0);
            end
            FMT_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                err_raw = !all_eq(imm_i, 20) || imm_i[0];
            end
            // LI is rewritten to I/U by the caller and never reaches here.
            FMT_LI: instr_o = 32'h0;
            FMT_RSVD: begin
                instr_o = 32'h0;
                err_raw = 1'b1;
            end
            default: instr_o = 32'h0;
        endcase
        err_o = CHECK_RANGE && err_raw;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32 instruction encoder with valid/ready in and out, a single-entry output
// register, and LI expansion into one or two words.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        out_last
);

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_err_q, hold_err_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_err_q, out_err_d;
    logic        out_last_q, out_last_d;

    fmt_e        req_fmt, p0_fmt;
    logic [6:0]  p0_opcode;
    logic [2:0]  p0_funct3;
    logic [4:0]  p0_rs1;
    logic [31:0] p0_imm;
    logic [31:0] p0_instr, p1_instr;
    logic        p0_err, p1_err;
    logic        is_li, li_fits, two_word, accept, out_fire;
    logic [19:0] li_hi;
    logic [31:0] li_lo;

    assign req_fmt  = fmt_e'(in_fmt);
    assign is_li    = (req_fmt == FMT_LI);
    assign li_fits  = all_eq(in_imm, 11);
    assign li_hi    = in_imm[31:12] + {19'h0, in_imm[11]};
    assign li_lo    = {{20{in_imm[11]}}, in_imm[11:0]};
    assign two_word = is_li && !li_fits && (in_imm[11:0] != 12'h0);

    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // LI becomes ADDI rd,x0,lo when it fits, otherwise LUI rd,hi first.
    always_comb begin
        p0_fmt    = req_fmt;
        p0_opcode = in_opcode;
        p0_funct3 = in_funct3;
        p0_rs1    = in_rs1;
        p0_imm    = in_imm;
        if (is_li) begin
            if (li_fits) begin
                p0_fmt    = FMT_I;
                p0_opcode = OP_OPIMM;
                p0_funct3 = F3_ADDI;
                p0_rs1    = 5'd0;
            end else begin
                p0_fmt    = FMT_U;
                p0_opcode = OP_LUI;
                p0_imm    = {li_hi, 12'h0};
            end
        end
    end

    instr_pack #(.CHECK_RANGE(CHECK_RANGE)) u_pack_req (
        .fmt_i    (p0_fmt),
        .opcode_i (p0_opcode),
        .funct3_i (p0_funct3),
        .funct7_i (in_funct7),
        .rd_i     (in_rd),
        .rs1_i    (p0_rs1),
        .rs2_i    (in_rs2),
        .imm_i    (p0_imm),
        .instr_o  (p0_instr),
        .err_o    (p0_err)
    );

    instr_pack #(.CHECK_RANGE(CHECK_RANGE)) u_pack_addi (
        .fmt_i    (FMT_I),
        .opcode_i (OP_OPIMM),
        .funct3_i (F3_ADDI),
        .funct7_i (7'h0),
        .rd_i     (in_rd),
        .rs1_i    (in_rd),
        .rs2_i    (5'd0),
        .imm_i    (li_lo),
        .instr_o  (p1_instr),
        .err_o    (p1_err)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_err_d  = hold_err_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        out_last_d  = out_last_q;
        if (state_q == StSecond) begin
            if (out_fire) begin
                out_valid_d = 1'b1;
                out_instr_d = hold_q;
                out_err_d   = hold_err_q;
                out_last_d  = 1'b1;
                hold_d      = 32'h0;
                hold_err_d  = 1'b0;
                state_d     = StIdle;
            end
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = p0_instr;
            out_err_d   = p0_err;
            out_last_d  = !two_word;
            if (two_word) begin
                hold_d     = p1_instr;
                hold_err_d = p1_err;
                state_d    = StSecond;
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hold_q      <= 32'h0;
            hold_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_err_q  <= hold_err_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: formats, errors, LI
// expansion, backpressure, mid-LI reset and back-to-back throughput.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        out_last;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_encoder #(.CHECK_RANGE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        exp_err;
    } vec_t;

    // Presents a request and waits (bounded) for the accepting edge; returns at edge+1.
    task automatic issue(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, output bit ok);
        in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid got %b exp 0", out_valid);
        end
        vectors++;
        if (out_instr !== 32'h0 || out_err !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outs got instr=%h err=%b last=%b exp 0/0/0",
                     out_instr, out_err, out_last);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_formats();
        vec_t v[13];
        bit ok;
        v[0]  = {3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0};
        v[1]  = {3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_8463, 1'b0};
        v[2]  = {3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0};
        v[3]  = {3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0003, 32'h0020_8163, 1'b1};
        v[4]  = {3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'h0000_0800, 32'h8001_0093, 1'b1};
        v[5]  = {3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_A423, 1'b0};
        v[6]  = {3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        v[7]  = {3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1};
        v[8]  = {3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h0020_81B3, 1'b0};
        v[9]  = {3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 32'h0000_0000, 1'b1};
        v[10] = {3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0001, 32'h0000_006F, 1'b1};
        v[11] = {3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800, 32'h8001_0093, 1'b0};
        v[12] = {3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0000_0000, 32'h4020_81B3, 1'b0};
        for (int i = 0; i < 13; i++) begin
            issue(v[i].fmt, v[i].op, v[i].f3, v[i].f7, v[i].rd, v[i].rs1, v[i].rs2,
                  v[i].imm, ok);
            vectors++;
            if (!ok || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL fmt_vec%0d_valid got accepted=%b valid=%b exp 1/1",
                         i, ok, out_valid);
            end
            vectors++;
            if (out_instr !== v[i].exp) begin
                miscompares++;
                $display("FAIL fmt_vec%0d_instr got %h exp %h", i, out_instr, v[i].exp);
            end
            vectors++;
            if (out_err !== v[i].exp_err || out_last !== 1'b1) begin
                miscompares++;
                $display("FAIL fmt_vec%0d_err_last got err=%b last=%b exp err=%b last=1",
                         i, out_err, out_last, v[i].exp_err);
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL fmt_drain got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_li();
        logic [4:0]  rd[4];
        logic [31:0] imm[4];
        logic [31:0] w0[4];
        logic [31:0] w1[4];
        logic        two[4];
        bit ok;
        rd[0] = 5'd5; imm[0] = 32'h1234_5678; w0[0] = 32'h1234_52B7; w1[0] = 32'h6782_8293;
        two[0] = 1'b1;
        rd[1] = 5'd1; imm[1] = 32'h0000_0800; w0[1] = 32'h0000_10B7; w1[1] = 32'h8000_8093;
        two[1] = 1'b1;
        rd[2] = 5'd3; imm[2] = 32'h0000_0005; w0[2] = 32'h0050_0193; w1[2] = 32'h0;
        two[2] = 1'b0;
        rd[3] = 5'd5; imm[3] = 32'h1234_5000; w0[3] = 32'h1234_52B7; w1[3] = 32'h0;
        two[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(3'd6, 7'h00, 3'd0, 7'h00, rd[i], 5'd0, 5'd0, imm[i], ok);
            vectors++;
            if (!ok || out_valid !== 1'b1 || out_instr !== w0[i] || out_err !== 1'b0) begin
                miscompares++;
                $display("FAIL li%0d_word0 got ok=%b valid=%b instr=%h err=%b exp 1/1/%h/0",
                         i, ok, out_valid, out_instr, out_err, w0[i]);
            end
            vectors++;
            if (out_last !== !two[i] || in_ready !== !two[i]) begin
                miscompares++;
                $display("FAIL li%0d_last got last=%b in_ready=%b exp %b/%b",
                         i, out_last, in_ready, !two[i], !two[i]);
            end
            @(posedge clk); #1;
            if (two[i]) begin
                vectors++;
                if (out_valid !== 1'b1 || out_instr !== w1[i] || out_last !== 1'b1
                    || out_err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL li%0d_word1 got valid=%b instr=%h last=%b err=%b exp 1/%h/1/0",
                             i, out_valid, out_instr, out_last, out_err, w1[i]);
                end
                @(posedge clk); #1;
            end
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++; $display("FAIL li%0d_drain got valid=%b exp 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        issue(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5678, ok);
        // Pending request that must wait until the ADDI word has left.
        in_fmt = 3'd1; in_opcode = 7'h13; in_funct3 = 3'd0; in_funct7 = 7'h00;
        in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd0; in_imm = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (!ok || out_valid !== 1'b1 || out_instr !== 32'h1234_52B7 || out_last !== 1'b0
                || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d got valid=%b instr=%h last=%b in_ready=%b exp 1/123452b7/0/0",
                         c, out_valid, out_instr, out_last, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_release_ready got %b exp 0", in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_instr !== 32'h6782_8293 || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_addi got valid=%b instr=%h last=%b exp 1/67828293/1",
                     out_valid, out_instr, out_last);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_instr !== 32'hFFF1_0093 || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_next got valid=%b instr=%h last=%b exp 1/fff10093/1",
                     out_valid, out_instr, out_last);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b0;
        issue(3'd6, 7'h00, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5678, ok);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (!ok || out_valid !== 1'b0 || out_instr !== 32'h0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_async got ok=%b valid=%b instr=%h last=%b exp 1/0/0/0",
                     ok, out_valid, out_instr, out_last);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_idle got in_ready=%b exp 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_dropped got valid=%b exp 0", out_valid);
        end
        issue(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, ok);
        vectors++;
        if (!ok || out_valid !== 1'b1 || out_instr !== 32'h0020_81B3 || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_add got ok=%b valid=%b instr=%h last=%b exp 1/1/002081b3/1",
                     ok, out_valid, out_instr, out_last);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_drain got valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp[8];
        exp = '{32'h0011_0093, 32'h0021_0093, 32'h0031_0093, 32'h0041_0093,
                32'h0051_0093, 32'h0061_0093, 32'h0071_0093, 32'h0081_0093};
        out_ready = 1'b1;
        in_fmt = 3'd1; in_opcode = 7'h13; in_funct3 = 3'd0; in_funct7 = 7'h00;
        in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd0;
        for (int k = 0; k < 8; k++) begin
            in_imm = 32'(k + 1);
            in_valid = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++; $display("FAIL b2b%0d_ready got %b exp 1", k, in_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_instr !== exp[k]) begin
                miscompares++;
                $display("FAIL b2b%0d_word got valid=%b instr=%h exp 1/%h",
                         k, out_valid, out_instr, exp[k]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_drain got valid=%b exp 0", out_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        in_fmt = 3'd0; in_opcode = 7'h0; in_funct3 = 3'd0; in_funct7 = 7'h0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_formats();
        test_li();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
